mem_stage: RTL



---
 rtl/mips_pkg.sv | 20 ++
 rtl/data_mem.sv | 32 +++
 rtl/mem_stage.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and constants for the MIPS memory-access stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int WORD_W          = 32;
    localparam int REG_ADDR_W      = 5;
    localparam int DEF_DEPTH_WORDS = 256;
    localparam int DEF_WAIT_CYCLES = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
// Module      : data_mem
// Description : Word-addressed data array, synchronous write / async read.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    // Contents are intentionally never reset.
    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];

endmodule : data_mem
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : MIPS MEM stage: branch resolve, wait-stated data memory,
//               upstream stall and the MEM/WB pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  branch_ex_mem,
    input  logic                  memRead_ex_mem,
    input  logic                  memWrite_ex_mem,
    input  logic                  regwrite_ex_mem,
    input  logic                  MemtoReg_ex_mem,
    input  logic [WORD_W-1:0]     pc_branch_target_ex_mem,
    input  logic [WORD_W-1:0]     result_ex_mem,
    input  logic [WORD_W-1:0]     B_ex_mem,
    input  logic                  zero_flag_ex_mem,
    input  logic [REG_ADDR_W-1:0] Reg_dest_op_ex_mem,
    output logic                  pcsrc,
    output logic [WORD_W-1:0]     pc_branch_target_out,
    output logic                  mem_stall,
    output logic                  regwrite_mem_wb,
    output logic                  MemtoReg_mem_wb,
    output logic [WORD_W-1:0]     read_data_mem_wb,
    output logic [WORD_W-1:0]     result_mem_wb,
    output logic [REG_ADDR_W-1:0] Reg_dest_op_mem_wb,
    output logic                  misalign_err_mem_wb
);

    localparam int c_aw     = $clog2(DEPTH_WORDS);
    localparam int c_cw     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int c_wait_m1 = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [c_cw-1:0] c_cnt_init = c_cw'(c_wait_m1);
    localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);

    mem_state_t        r_state, w_state_nxt;
    logic [c_cw-1:0]   r_cnt, w_cnt_nxt;
    logic              w_stall, w_retire;
    logic              w_req, w_aligned, w_access, w_misalign, w_is_load, w_we;
    logic [WORD_W-1:0] w_mem_rdata, w_rd_data;

    assign pcsrc                = branch_ex_mem & zero_flag_ex_mem;
    assign pc_branch_target_out = pc_branch_target_ex_mem;

    assign w_req      = memRead_ex_mem | memWrite_ex_mem;
    assign w_aligned  = (result_ex_mem[1:0] == 2'b00);
    assign w_access   = w_req & w_aligned;
    assign w_misalign = w_req & ~w_aligned;
    // A simultaneous read+write strobe is a store, so it never returns data.
    assign w_is_load  = w_access & memRead_ex_mem & ~memWrite_ex_mem;
    assign w_rd_data  = w_is_load ? w_mem_rdata : '0;
    assign w_we       = w_retire & w_access & memWrite_ex_mem & ~reset;

    data_mem #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_data_mem (
        .clk   (clk),
        .we    (w_we),
        .addr  (result_ex_mem[c_aw+1:2]),
        .wdata (B_ex_mem),
        .rdata (w_mem_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access && (WAIT_CYCLES > 0)) begin
                    w_stall     = 1'b1;
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = c_cnt_init;
                end else begin
                    w_retire = 1'b1;
                end
            end
            BUSY: begin
                if (r_cnt != '0) begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end else begin
                    w_retire    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign mem_stall = w_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state             <= IDLE;
            r_cnt               <= '0;
            regwrite_mem_wb     <= 1'b0;
            MemtoReg_mem_wb     <= 1'b0;
            read_data_mem_wb    <= '0;
            result_mem_wb       <= '0;
            Reg_dest_op_mem_wb  <= '0;
            misalign_err_mem_wb <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_retire) begin
                regwrite_mem_wb     <= regwrite_ex_mem & ~w_misalign;
                MemtoReg_mem_wb     <= MemtoReg_ex_mem;
                read_data_mem_wb    <= w_rd_data;
                result_mem_wb       <= result_ex_mem;
                Reg_dest_op_mem_wb  <= Reg_dest_op_ex_mem;
                misalign_err_mem_wb <= w_misalign;
            end else begin
                regwrite_mem_wb     <= 1'b0;
                MemtoReg_mem_wb     <= 1'b0;
                read_data_mem_wb    <= '0;
                result_mem_wb       <= '0;
                Reg_dest_op_mem_wb  <= '0;
                misalign_err_mem_wb <= 1'b0;
            end
        end
    end

endmodule : mem_stage
`default_nettype wire
